// File: rtl/i2c_periph_pkg.sv
// Shared types and defaults for the I2C register peripheral.
// Holds the controller state encoding and the majority helper used by the optional glitch filter.
package i2c_periph_pkg;

    localparam logic [6:0] DEFAULT_I2C_ADDR = 7'h2A;
    localparam int         DEFAULT_NUM_REGS = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_PTR,
        ST_ACK_PTR,
        ST_WDATA,
        ST_ACK_WDATA,
        ST_RDATA,
        ST_RACK
    } i2c_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Brings one open-drain bus line into the clk domain and reports its level and edges.
// With I2C_GLITCH_FILTER_EN defined, a 3-sample majority filter follows the synchronizer.
module i2c_line_sync
    import i2c_periph_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Reset to 1 so an idle bus produces no spurious edge when reset releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync_q[1]};
            filt_q <= maj3(sync_q[1], hist_q[0], hist_q[1]);
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/tt_um_i2c_peripheral_stevej_core.sv
// I2C target with a pointer byte and NUM_REGS 8-bit registers; register 0 is mirrored on uo_out.
// Optional I2C_GLITCH_FILTER_EN adds a majority filter inside each i2c_line_sync.
//
// state        | meaning
// ST_IDLE      | not addressed, waiting for START
// ST_ADDR      | shifting in address + R/W
// ST_ACK_ADDR  | acknowledging address
// ST_PTR       | shifting in register pointer
// ST_ACK_PTR   | acknowledging pointer
// ST_WDATA     | shifting in write data
// ST_ACK_WDATA | acknowledging write data
// ST_RDATA     | shifting out reg[ptr]
// ST_RACK      | sampling controller ACK/NACK after a read byte
module tt_um_i2c_peripheral_stevej_core
    import i2c_periph_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR = DEFAULT_I2C_ADDR,
    parameter int         NUM_REGS = DEFAULT_NUM_REGS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int PTR_W = $clog2(NUM_REGS);

    logic sda, sda_rise, sda_fall;
    logic scl, scl_rise, scl_fall;

    i2c_line_sync u_sda_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (uio_in[0]),
        .level   (sda),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    i2c_line_sync u_scl_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (uio_in[1]),
        .level   (scl),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_state_t       state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       tx_q, tx_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [1:0]       phase_q, phase_d;
    logic             rw_q, rw_d;
    logic             oe_q, oe_d;
    logic             wr_en;
    logic [7:0]       regs_q [NUM_REGS];

    logic       start_cond, stop_cond;
    logic [7:0] rx_byte;

    assign start_cond = sda_fall & scl;
    assign stop_cond  = sda_rise & scl;
    assign rx_byte    = {shift_q[6:0], sda};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 8'h00;
            ptr_q     <= '0;
            phase_q   <= 2'd0;
            rw_q      <= 1'b0;
            oe_q      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            phase_q   <= phase_d;
            rw_q      <= rw_d;
            oe_q      <= oe_d;
            if (wr_en) begin
                regs_q[ptr_q] <= rx_byte;
            end
        end
    end

    // Ack phases: 0 = wait for the fall ending bit 8 before driving,
    // 1 = driving, release on the fall ending the ack clock.
    // RACK phases: 0 = release last data bit, 1 = sample ack, 2 = load next byte.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        phase_d   = phase_q;
        rw_d      = rw_q;
        oe_d      = oe_q;
        wr_en     = 1'b0;

        if (start_cond) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            phase_d   = 2'd0;
            oe_d      = 1'b0;
        end else if (stop_cond) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            phase_d   = 2'd0;
            oe_d      = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            phase_d = 2'd0;
                            case (state_q)
                                ST_ADDR: begin
                                    if (rx_byte[7:1] == I2C_ADDR) begin
                                        state_d = ST_ACK_ADDR;
                                        rw_d    = rx_byte[0];
                                    end else begin
                                        state_d = ST_IDLE;
                                    end
                                end
                                ST_PTR: begin
                                    ptr_d   = rx_byte[PTR_W-1:0];
                                    state_d = ST_ACK_PTR;
                                end
                                default: begin
                                    wr_en   = 1'b1;
                                    ptr_d   = ptr_q + PTR_W'(1);
                                    state_d = ST_ACK_WDATA;
                                end
                            endcase
                        end
                    end
                end

                ST_ACK_ADDR, ST_ACK_PTR, ST_ACK_WDATA: begin
                    if (scl_fall) begin
                        if (phase_q == 2'd0) begin
                            oe_d    = 1'b1;
                            phase_d = 2'd1;
                        end else begin
                            oe_d      = 1'b0;
                            phase_d   = 2'd0;
                            bit_cnt_d = 3'd0;
                            if (state_q == ST_ACK_ADDR) begin
                                if (rw_q) begin
                                    state_d = ST_RDATA;
                                    tx_d    = regs_q[ptr_q];
                                    oe_d    = ~regs_q[ptr_q][7];
                                end else begin
                                    state_d = ST_PTR;
                                end
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end

                ST_RDATA: begin
                    if (scl_rise) begin
                        if (bit_cnt_q == 3'd7) begin
                            state_d   = ST_RACK;
                            bit_cnt_d = 3'd0;
                            phase_d   = 2'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else if (scl_fall) begin
                        tx_d = {tx_q[6:0], 1'b0};
                        oe_d = ~tx_q[6];
                    end
                end

                ST_RACK: begin
                    case (phase_q)
                        2'd0: begin
                            if (scl_fall) begin
                                oe_d    = 1'b0;
                                phase_d = 2'd1;
                            end
                        end
                        2'd1: begin
                            if (scl_rise) begin
                                if (sda) begin
                                    state_d = ST_IDLE;
                                    phase_d = 2'd0;
                                end else begin
                                    ptr_d   = ptr_q + PTR_W'(1);
                                    phase_d = 2'd2;
                                end
                            end
                        end
                        default: begin
                            if (scl_fall) begin
                                state_d   = ST_RDATA;
                                tx_d      = regs_q[ptr_q];
                                oe_d      = ~regs_q[ptr_q][7];
                                bit_cnt_d = 3'd0;
                                phase_d   = 2'd0;
                            end
                        end
                    endcase
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, ui_in, uio_in[7:2]};

    assign uo_out  = regs_q[0];
    assign uio_out = 8'h00;
    assign uio_oe  = {7'b0000000, oe_q};

endmodule

// File: tb/tb_tt_um_i2c_peripheral_stevej_core.sv
// Bench for the I2C register peripheral: a bit-banged controller against a transaction-level
// register/pointer model, with fixed scenarios followed by randomized transactions.
module tb_tt_um_i2c_peripheral_stevej_core;

    localparam int         Q    = 6;
    localparam int         NREG = 4;
    localparam logic [6:0] ADDR = 7'h2A;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic sda_ctl;
    logic scl_ctl;
    logic sda_line;

    assign sda_line = sda_ctl & ~uio_oe[0];
    assign uio_in   = {6'b000000, scl_ctl, sda_line};

    tt_um_i2c_peripheral_stevej_core dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int oe_hi_cnt = 0;

    always @(posedge clk) begin
        if (uio_oe != 8'h00) oe_hi_cnt <= oe_hi_cnt + 1;
    end

    logic [7:0] m_regs [NREG];
    int         m_ptr;
    logic [7:0] wbuf [8];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
    endtask

    task automatic i2c_start();
        sda_ctl = 1'b1; tick(Q);
        scl_ctl = 1'b1; tick(Q);
        sda_ctl = 1'b0; tick(Q);
        scl_ctl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_ctl = 1'b0; tick(Q);
        scl_ctl = 1'b1; tick(Q);
        sda_ctl = 1'b1; tick(Q);
    endtask

    task automatic bit_out(input logic b);
        sda_ctl = b;    tick(Q);
        scl_ctl = 1'b1; tick(2 * Q);
        scl_ctl = 1'b0; tick(Q);
    endtask

    task automatic bit_in(output logic b);
        sda_ctl = 1'b1; tick(Q);
        scl_ctl = 1'b1; tick(Q);
        b = sda_line;   tick(Q);
        scl_ctl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(b);
        ack = ~b;
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            d[i] = b;
        end
        bit_out(nack);
    endtask

    task automatic xfer_write(input logic [6:0] addr, input logic [7:0] ptr_b, input int n,
                              input string tag);
        logic ack;
        logic hit;
        int   oe_before;
        hit       = (addr == ADDR);
        oe_before = oe_hi_cnt;
        i2c_start();
        send_byte({addr, 1'b0}, ack);
        check_val({tag, " addr_ack"}, ack, hit);
        send_byte(ptr_b, ack);
        check_val({tag, " ptr_ack"}, ack, hit);
        if (hit) m_ptr = ptr_b % NREG;
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], ack);
            check_val({tag, " data_ack"}, ack, hit);
            if (hit) begin
                m_regs[m_ptr] = wbuf[i];
                m_ptr = (m_ptr + 1) % NREG;
            end
        end
        i2c_stop();
        tick(4);
        check_val({tag, " uo_out"}, uo_out, m_regs[0]);
        check_val({tag, " uio_oe"}, uio_oe, 8'h00);
        check_val({tag, " uio_out"}, uio_out, 8'h00);
        if (!hit) check_val({tag, " no_drive"}, oe_hi_cnt - oe_before, 0);
    endtask

    task automatic xfer_read(input logic set_ptr, input logic [7:0] ptr_b, input int n,
                             input string tag);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        if (set_ptr) begin
            send_byte({ADDR, 1'b0}, ack);
            check_val({tag, " waddr_ack"}, ack, 1'b1);
            send_byte(ptr_b, ack);
            check_val({tag, " ptr_ack"}, ack, 1'b1);
            m_ptr = ptr_b % NREG;
            i2c_start();
        end
        send_byte({ADDR, 1'b1}, ack);
        check_val({tag, " raddr_ack"}, ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            recv_byte(d, i == n - 1);
            check_val({tag, " rdata"}, d, m_regs[m_ptr]);
            if (i < n - 1) m_ptr = (m_ptr + 1) % NREG;
        end
        i2c_stop();
        tick(4);
        check_val({tag, " released"}, uio_oe, 8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic [6:0] bad;
        int         kind;
        int         n;

        rst = 1'b1; ena = 1'b1; ui_in = 8'h00;
        sda_ctl = 1'b1; scl_ctl = 1'b1;
        tick(5);
        check_val("reset uo_out", uo_out, 8'h00);
        check_val("reset uio_oe", uio_oe, 8'h00);
        check_val("reset uio_out", uio_out, 8'h00);
        rst = 1'b0;
        tick(5);
        model_reset();

        wbuf[0] = 8'hA5;
        xfer_write(ADDR, 8'h00, 1, "wr_basic");
        check_val("wr_basic mirror", uo_out, 8'hA5);

        wbuf[0] = 8'h3C;
        xfer_write(ADDR, 8'h01, 1, "preload");
        xfer_read(1'b1, 8'h01, 1, "rd_basic");

        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        xfer_write(ADDR, 8'h03, 2, "wrap");
        check_val("wrap mirror", uo_out, 8'h22);
        xfer_read(1'b1, 8'h03, 2, "wrap_rd");

        wbuf[0] = 8'h77;
        xfer_write(ADDR, 8'hFE, 1, "ptr_oor");
        xfer_read(1'b1, 8'h02, 1, "ptr_oor_rd");

        xfer_write(7'h2B, 8'hFF, 0, "wrong_addr");
        xfer_read(1'b1, 8'h00, 4, "wrong_addr_rd");

        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 3);
            n    = $urandom_range(1, 3);
            case (kind)
                0: begin
                    for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                    xfer_write(ADDR, 8'($urandom), n, "rnd_wr");
                end
                1: xfer_read(1'b1, 8'($urandom), n, "rnd_rd");
                2: xfer_read(1'b0, 8'h00, n, "rnd_cur_rd");
                default: begin
                    bad = 7'($urandom);
                    if (bad == ADDR) bad = ADDR + 7'd1;
                    wbuf[0] = 8'($urandom);
                    xfer_write(bad, 8'($urandom), 1, "rnd_bad");
                end
            endcase
        end

        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
        xfer_write(ADDR, 8'h00, 2, "pre_reset");
        i2c_start();
        send_byte({ADDR, 1'b0}, ack);
        check_val("midrst addr_ack", ack, 1'b1);
        send_byte(8'h00, ack);
        check_val("midrst ptr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) bit_out(1'b1);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        model_reset();
        check_val("midrst uo_out", uo_out, 8'h00);
        check_val("midrst uio_oe", uio_oe, 8'h00);
        send_byte({ADDR, 1'b0}, ack);
        check_val("midrst no_start_ack", ack, 1'b0);
        i2c_stop();
        xfer_read(1'b1, 8'h00, 4, "midrst_rd");

`ifdef I2C_GLITCH_FILTER_EN
        begin : glitch_blk
            logic       b;
            logic [7:0] gb;
            gb = 8'h96;
            i2c_start();
            send_byte({ADDR, 1'b0}, ack);
            check_val("glitch addr_ack", ack, 1'b1);
            send_byte(8'h01, ack);
            check_val("glitch ptr_ack", ack, 1'b1);
            m_ptr = 1;
            for (int i = 7; i >= 0; i--) begin
                sda_ctl = gb[i];
                tick(2);
                if (i == 4) begin
                    scl_ctl = 1'b1; tick(1); scl_ctl = 1'b0;
                end else begin
                    tick(1);
                end
                tick(Q - 3);
                scl_ctl = 1'b1; tick(2 * Q);
                scl_ctl = 1'b0; tick(Q);
            end
            bit_in(b);
            check_val("glitch data_ack", ~b, 1'b1);
            m_regs[1] = gb;
            m_ptr = 2;
            i2c_stop();
            xfer_read(1'b1, 8'h01, 1, "glitch_rd");
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
